// File: rtl/fir_cfg_pkg.sv
// rtl/fir_cfg_pkg.sv - shared types and constants for the FIR coefficient config loader
package fir_cfg_pkg;

  localparam int CFG_DATA_W    = 8;
  localparam int CFG_NUM_TAPS  = 16;
  localparam int CFG_FRAME_LEN = 17;

  localparam logic [7:0] CFG_COEF_RESET   = 8'h40;
  localparam logic [3:0] CFG_TAPNUM_RESET = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    GAP,
    HOLD
  } cfg_state_e;

endpackage

// File: rtl/fir_cfg_loader_if.sv
// rtl/fir_cfg_loader_if.sv - host request / FIR config port bundle; FIR_CFG_LOADER_CHECKSUM_EN adds cfg_checksum
interface fir_cfg_loader_if #(
  parameter int NUM_TAPS = 16,
  parameter int DATA_W   = 8
);

  logic                  start;
  logic                  abort;
  logic [NUM_TAPS*8-1:0] coef_flat;
  logic [3:0]            tap_num_in;
  logic                  start_ready;
  logic                  cfg_enable;
  logic                  cfg_data_enable;
  logic [DATA_W-1:0]     cfg_data_out;
  logic                  done;
  logic                  aborted;
`ifdef FIR_CFG_LOADER_CHECKSUM_EN
  logic [7:0]            cfg_checksum;
`endif

  modport master (
    output start, abort, coef_flat, tap_num_in,
    input  start_ready, cfg_enable, cfg_data_enable, cfg_data_out, done, aborted
`ifdef FIR_CFG_LOADER_CHECKSUM_EN
    , input cfg_checksum
`endif
  );

  modport slave (
    input  start, abort, coef_flat, tap_num_in,
    output start_ready, cfg_enable, cfg_data_enable, cfg_data_out, done, aborted
`ifdef FIR_CFG_LOADER_CHECKSUM_EN
    , output cfg_checksum
`endif
  );

endinterface

// File: rtl/fir_cfg_frame_mux.sv
// rtl/fir_cfg_frame_mux.sv - byte index to frame byte select: index 0 is the tap count, then h[N-1] down to h[0]
module fir_cfg_frame_mux #(
  parameter int DATA_W   = 8,
  parameter int NUM_TAPS = 16,
  parameter int IDX_W    = 5
) (
  input  logic [NUM_TAPS*DATA_W-1:0] coef_flat,
  input  logic [3:0]                 tap_num,
  input  logic [IDX_W-1:0]           byte_idx,
  output logic [DATA_W-1:0]          frame_byte
);

  always_comb begin
    frame_byte = '0;
    if (byte_idx == '0) begin
      frame_byte = DATA_W'(tap_num);
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (byte_idx == IDX_W'(NUM_TAPS - i)) begin
          frame_byte = coef_flat[DATA_W*i +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/fir_cfg_loader.sv
// rtl/fir_cfg_loader.sv - serialises a coefficient set into the FIR config shift-register port
// Optional FIR_CFG_LOADER_CHECKSUM_EN: modulo-256 sum of the frame bytes on cfg_checksum.
module fir_cfg_loader
  import fir_cfg_pkg::*;
#(
  parameter int DATA_W     = CFG_DATA_W,
  parameter int NUM_TAPS   = CFG_NUM_TAPS,
  parameter int GAP_CYCLES = 0
) (
  input logic        clk,
  input logic        rst_n,
  fir_cfg_loader_if.slave bus
);

  localparam int               IDX_W    = $clog2(NUM_TAPS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

  cfg_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            byte_q, byte_d;
  logic [3:0]                  gap_q, gap_d;
  logic [NUM_TAPS*DATA_W-1:0]  coef_q, coef_d;
  logic [3:0]                  tap_q, tap_d;
  logic                        start_ready_q, start_ready_d;
  logic                        cfg_enable_q, cfg_enable_d;
  logic                        cfg_data_enable_q, cfg_data_enable_d;
  logic [DATA_W-1:0]           cfg_data_out_q, cfg_data_out_d;
  logic                        done_q, done_d;
  logic                        aborted_q, aborted_d;
  logic [DATA_W-1:0]           mux_byte;
  logic                        accept;

  // The mux looks at the next byte index so the byte lands in the same register as its pulse.
  fir_cfg_frame_mux #(
    .DATA_W   (DATA_W),
    .NUM_TAPS (NUM_TAPS),
    .IDX_W    (IDX_W)
  ) u_frame_mux (
    .coef_flat  (coef_q),
    .tap_num    (tap_q),
    .byte_idx   (byte_d),
    .frame_byte (mux_byte)
  );

  assign accept = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    gap_d     = gap_q;
    coef_d    = coef_q;
    tap_d     = tap_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          coef_d  = bus.coef_flat;
          tap_d   = bus.tap_num_in;
          byte_d  = '0;
          gap_d   = '0;
        end
      end
      SETUP: begin
        state_d = SEND;
        byte_d  = '0;
      end
      SEND: begin
        if (byte_q == LAST_IDX) begin
          state_d = HOLD;
        end else if (GAP_CYCLES == 0) begin
          byte_d = byte_q + 1'b1;
        end else begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = SEND;
          byte_d  = byte_q + 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including the done that HOLD would raise.
    if ((state_q != IDLE) && bus.abort) begin
      state_d   = IDLE;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end

    start_ready_d     = (state_d == IDLE);
    cfg_enable_d      = (state_d != IDLE);
    cfg_data_enable_d = (state_d == SEND);
    cfg_data_out_d    = cfg_data_enable_d ? mux_byte : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      byte_q            <= '0;
      gap_q             <= '0;
      coef_q            <= {NUM_TAPS{DATA_W'(CFG_COEF_RESET)}};
      tap_q             <= CFG_TAPNUM_RESET;
      start_ready_q     <= 1'b1;
      cfg_enable_q      <= 1'b0;
      cfg_data_enable_q <= 1'b0;
      cfg_data_out_q    <= '0;
      done_q            <= 1'b0;
      aborted_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      byte_q            <= byte_d;
      gap_q             <= gap_d;
      coef_q            <= coef_d;
      tap_q             <= tap_d;
      start_ready_q     <= start_ready_d;
      cfg_enable_q      <= cfg_enable_d;
      cfg_data_enable_q <= cfg_data_enable_d;
      cfg_data_out_q    <= cfg_data_out_d;
      done_q            <= done_d;
      aborted_q         <= aborted_d;
    end
  end

  assign bus.start_ready     = start_ready_q;
  assign bus.cfg_enable      = cfg_enable_q;
  assign bus.cfg_data_enable = cfg_data_enable_q;
  assign bus.cfg_data_out    = cfg_data_out_q;
  assign bus.done            = done_q;
  assign bus.aborted         = aborted_q;

`ifdef FIR_CFG_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (accept) begin
      checksum_d = '0;
    end else if (cfg_data_enable_d) begin
      checksum_d = checksum_q + 8'(cfg_data_out_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.cfg_checksum = checksum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fir_cfg_loader.sv
// tb/tb_fir_cfg_loader.sv - directed bench: GAP=0 and GAP=2 loaders feeding config shift-register models
module tb_fir_cfg_loader;
  import fir_cfg_pkg::*;

  logic clk;
  logic rst_n;

  fir_cfg_loader_if #(.NUM_TAPS(16), .DATA_W(8)) if0 ();
  fir_cfg_loader_if #(.NUM_TAPS(16), .DATA_W(8)) if2 ();

  fir_cfg_loader #(.DATA_W(8), .NUM_TAPS(16), .GAP_CYCLES(0)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (if0)
  );
  fir_cfg_loader #(.DATA_W(8), .NUM_TAPS(16), .GAP_CYCLES(2)) dut2 (
    .clk (clk), .rst_n (rst_n), .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Filter-side config shift registers: new byte enters h_0, h_15 feeds tap_num.
  logic [15:0][7:0] rx0_h, rx2_h;
  logic [3:0]       rx0_t, rx2_t;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx0_h <= {16{CFG_COEF_RESET}};
      rx0_t <= CFG_TAPNUM_RESET;
    end else if (if0.cfg_enable && if0.cfg_data_enable) begin
      rx0_t <= rx0_h[15][3:0];
      rx0_h <= {rx0_h[14:0], if0.cfg_data_out};
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx2_h <= {16{CFG_COEF_RESET}};
      rx2_t <= CFG_TAPNUM_RESET;
    end else if (if2.cfg_enable && if2.cfg_data_enable) begin
      rx2_t <= rx2_h[15][3:0];
      rx2_h <= {rx2_h[14:0], if2.cfg_data_out};
    end
  end

  logic       sel;
  logic       s_en, s_de, s_done, s_ab, s_rdy;
  logic [7:0] s_data;
  logic [7:0] s_sum;

  always_comb begin
    s_en   = sel ? if2.cfg_enable      : if0.cfg_enable;
    s_de   = sel ? if2.cfg_data_enable : if0.cfg_data_enable;
    s_done = sel ? if2.done            : if0.done;
    s_ab   = sel ? if2.aborted         : if0.aborted;
    s_rdy  = sel ? if2.start_ready     : if0.start_ready;
    s_data = sel ? if2.cfg_data_out    : if0.cfg_data_out;
`ifdef FIR_CFG_LOADER_CHECKSUM_EN
    s_sum  = sel ? if2.cfg_checksum    : if0.cfg_checksum;
`else
    s_sum  = 8'h00;
`endif
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic ab, input logic [127:0] c, input logic [3:0] t);
    if (sel) begin
      if2.start = st; if2.abort = ab; if2.coef_flat = c; if2.tap_num_in = t;
      if0.start = 1'b0; if0.abort = 1'b0;
    end else begin
      if0.start = st; if0.abort = ab; if0.coef_flat = c; if0.tap_num_in = t;
      if2.start = 1'b0; if2.abort = 1'b0;
    end
  endtask

  int         n_pulse, done_cyc, ab_cyc, zero_err, en_err;
  logic       en_at_end, rdy_at_end;
  logic [7:0] bytes [32];
  int         pcyc [32];

  // Cycle 0 is the accept cycle; each negedge samples outputs then drives the next inputs.
  task automatic run_frame(input logic s, input logic [127:0] coef, input logic [3:0] tap,
                           input int abort_cyc, input int mid_start, input logic start_abort);
    int cyc;
    logic [127:0] c;
    sel = s;
    n_pulse = 0; done_cyc = -1; ab_cyc = -1; zero_err = 0; en_err = 0;
    en_at_end = 1'bx; rdy_at_end = 1'bx;
    @(negedge clk);
    check("ready_before_start", s_rdy, 1'b1);
    cyc = 0;
    set_in(1'b1, start_abort, coef, tap);
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s_de) begin
        if (n_pulse < 32) begin
          bytes[n_pulse] = s_data;
          pcyc[n_pulse]  = cyc;
        end
        n_pulse++;
      end else if (s_data != 8'h00) begin
        zero_err++;
      end
      if (s_done || s_ab) begin
        if (s_done) done_cyc = cyc;
        if (s_ab) ab_cyc = cyc;
        en_at_end  = s_en;
        rdy_at_end = s_rdy;
        break;
      end
      if (!s_en || s_rdy) en_err++;
      c = (mid_start > 0 && cyc >= mid_start) ? ~coef : coef;
      set_in((mid_start > 0 && cyc == mid_start), (cyc == abort_cyc), c,
             (mid_start > 0 && cyc >= mid_start) ? 4'd3 : tap);
    end
    set_in(1'b0, 1'b0, coef, tap);
    check("frame_terminated", (done_cyc >= 0) || (ab_cyc >= 0), 1'b1);
  endtask

  task automatic check_full(input string nm, input logic s, input logic [127:0] coef,
                            input logic [3:0] tap, input int exp_done);
    int sp_err, seq_err, g;
    g = s ? 3 : 1;
    sp_err = 0; seq_err = 0;
    for (int k = 0; k < CFG_FRAME_LEN && k < n_pulse; k++) begin
      if (pcyc[k] != 2 + k * g) sp_err++;
      if (k > 0 && bytes[k] != coef[8*(16-k) +: 8]) seq_err++;
    end
    check({nm, "_pulses"}, n_pulse, CFG_FRAME_LEN);
    check({nm, "_timing"}, sp_err, 0);
    check({nm, "_byte_seq"}, seq_err, 0);
    check({nm, "_done_cyc"}, done_cyc, exp_done);
    check({nm, "_aborted"}, ab_cyc, -1);
    check({nm, "_idle_data"}, zero_err, 0);
    check({nm, "_busy_flags"}, en_err, 0);
    check({nm, "_end_flags"}, {en_at_end, rdy_at_end}, 2'b01);
    check({nm, "_rx_coef"}, s ? rx2_h : rx0_h, coef);
    check({nm, "_rx_tap"}, s ? rx2_t : rx0_t, tap);
  endtask

  typedef struct {
    logic         sel;
    logic [127:0] coef;
    logic [3:0]   tap;
    logic [7:0]   b0, b1, b16;
    int           done_at;
    int           last_pulse;
    logic [7:0]   csum;
  } vec_t;

  typedef struct {
    logic sel;
    int   abort_cyc;
    int   exp_pulses;
    int   exp_ab_cyc;
  } abt_t;

  vec_t         vt [5];
  abt_t         at [5];
  logic [127:0] ramp, hi_ramp, a5;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramp[8*i +: 8]    = 8'(i + 1);
      hi_ramp[8*i +: 8] = 8'(8'h80 + i);
      a5[8*i +: 8]      = 8'hA5;
    end
    a5[7:0]     = 8'h3C;
    a5[127:120] = 8'hC3;

    vt[0] = '{1'b0, ramp,            4'd7,  8'h07, 8'h10, 8'h01, 20, 18, 8'h8F};
    vt[1] = '{1'b1, ramp,            4'd7,  8'h07, 8'h10, 8'h01, 52, 50, 8'h8F};
    vt[2] = '{1'b0, a5,              4'd15, 8'h0F, 8'hC3, 8'h3C, 20, 18, 8'h14};
    vt[3] = '{1'b1, hi_ramp,         4'd0,  8'h00, 8'h8F, 8'h80, 52, 50, 8'h78};
    vt[4] = '{1'b0, {16{8'hFF}},     4'd15, 8'h0F, 8'hFF, 8'hFF, 20, 18, 8'hFF};

    // abort in SEND after 5th pulse, SETUP, GAP, last pulse, HOLD
    at[0] = '{1'b0, 6,  5,  7};
    at[1] = '{1'b0, 1,  0,  2};
    at[2] = '{1'b1, 3,  1,  4};
    at[3] = '{1'b0, 18, 17, 19};
    at[4] = '{1'b0, 19, 17, 20};

    sel = 1'b0;
    if0.start = 1'b0; if0.abort = 1'b0; if0.coef_flat = '0; if0.tap_num_in = '0;
    if2.start = 1'b0; if2.abort = 1'b0; if2.coef_flat = '0; if2.tap_num_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_outputs0", {if0.cfg_enable, if0.cfg_data_enable, if0.cfg_data_out,
                             if0.done, if0.aborted, if0.start_ready}, 13'h0001);
    check("reset_outputs2", {if2.cfg_enable, if2.cfg_data_enable, if2.cfg_data_out,
                             if2.done, if2.aborted, if2.start_ready}, 13'h0001);
    check("reset_rx_coef", rx0_h, {16{8'h40}});
    check("reset_rx_tap", rx0_t, 4'd15);

    for (int v = 0; v < 5; v++) begin
      run_frame(vt[v].sel, vt[v].coef, vt[v].tap, -1, 0, 1'b0);
      check_full($sformatf("vec%0d", v), vt[v].sel, vt[v].coef, vt[v].tap, vt[v].done_at);
      check($sformatf("vec%0d_byte0", v), bytes[0], vt[v].b0);
      check($sformatf("vec%0d_byte1", v), bytes[1], vt[v].b1);
      check($sformatf("vec%0d_byte16", v), bytes[16], vt[v].b16);
      check($sformatf("vec%0d_last_pulse", v), pcyc[16], vt[v].last_pulse);
`ifdef FIR_CFG_LOADER_CHECKSUM_EN
      check($sformatf("vec%0d_checksum", v), s_sum, vt[v].csum);
`endif
    end

    for (int a = 0; a < 5; a++) begin
      run_frame(at[a].sel, ramp, 4'd7, at[a].abort_cyc, 0, 1'b0);
      check($sformatf("abort%0d_pulses", a), n_pulse, at[a].exp_pulses);
      check($sformatf("abort%0d_cyc", a), ab_cyc, at[a].exp_ab_cyc);
      check($sformatf("abort%0d_no_done", a), done_cyc, -1);
      check($sformatf("abort%0d_end_flags", a), {en_at_end, rdy_at_end}, 2'b01);
      run_frame(at[a].sel, a5, 4'd9, -1, 0, 1'b0);
      check_full($sformatf("restart%0d", a), at[a].sel, a5, 4'd9, at[a].sel ? 52 : 20);
    end

    // start and abort together in IDLE: start wins
    run_frame(1'b0, ramp, 4'd7, -1, 0, 1'b1);
    check_full("start_abort_idle", 1'b0, ramp, 4'd7, 20);

    // abort alone in IDLE is ignored
    sel = 1'b0;
    @(negedge clk);
    set_in(1'b0, 1'b1, ramp, 4'd7);
    @(negedge clk);
    set_in(1'b0, 1'b0, ramp, 4'd7);
    check("idle_abort_ignored", {if0.aborted, if0.cfg_enable, if0.start_ready}, 3'b001);

    // start with new coefficients mid-frame is ignored
    run_frame(1'b0, hi_ramp, 4'd5, -1, 8, 1'b0);
    check_full("mid_start", 1'b0, hi_ramp, 4'd5, 20);

    // asynchronous reset mid-frame
    sel = 1'b0;
    @(negedge clk);
    set_in(1'b1, 1'b0, ramp, 4'd7);
    @(negedge clk);
    set_in(1'b0, 1'b0, ramp, 4'd7);
    repeat (5) @(negedge clk);
    check("pre_reset_pulse", {if0.cfg_enable, if0.cfg_data_enable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {if0.cfg_enable, if0.cfg_data_enable, if0.cfg_data_out,
                                  if0.done, if0.aborted, if0.start_ready}, 13'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", if0.start_ready, 1'b1);
    run_frame(1'b0, ramp, 4'd7, -1, 0, 1'b0);
    check_full("post_reset", 1'b0, ramp, 4'd7, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
